// File: rtl/blur_pkg.sv
// Shared definitions for the 3x3 blur window generator: default pixel width,
// window tap indices, blur kernel codes and the frame-tracking FSM states.
package blur_pkg;

    localparam int DEF_DATA_WIDTH = 12;

    localparam int TAP_COUNT  = 9;
    localparam int TAP_OLDEST = 0;
    localparam int TAP_CENTER = 4;
    localparam int TAP_NEWEST = 8;

    localparam logic [2:0] FREQ_1X1 = 3'b000;
    localparam logic [2:0] FREQ_3X3 = 3'b010;
    localparam logic [2:0] FREQ_5X5 = 3'b100;
    localparam logic [2:0] FREQ_7X7 = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_DONE
    } state_t;

    // Row 0 is the oldest line and column 0 the oldest pixel.
    function automatic int tap_index(input int r, input int c);
        return 3 * r + c;
    endfunction

endpackage

// File: rtl/line_ram.sv
// Single-port line buffer: combinational read of the old word and synchronous
// write at the same address, so each access is read-before-write.
module line_ram #(
    parameter int DEPTH = 640,
    parameter int WIDTH = 12
) (
    input  logic                                 clk,
    input  logic                                 we,
    input  logic [(DEPTH > 1 ? $clog2(DEPTH) : 1)-1:0] addr,
    input  logic [WIDTH-1:0]                     wdata,
    output logic [WIDTH-1:0]                     rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/blur_window_gen.sv
// Streams a raster image into a 3x3 sliding window for a blur filter.
// Optional macro BLUR_WINDOW_EDGE_FILL_EN emits zero-padded windows for every pixel.
module blur_window_gen
    import blur_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_in,
    input  logic                    sof_in,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic [2:0]              freq_flag_in,
    output logic [9*DATA_WIDTH-1:0] win_out,
    output logic                    win_valid,
    output logic [2:0]              freq_flag_out,
    output logic                    eol_out,
    output logic                    eof_out,
    output logic                    frame_err
);

    localparam int COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

    state_t state;
    state_t state_next;

    logic [COL_W-1:0]      col;
    logic [ROW_W-1:0]      row;
    logic [COL_W-1:0]      pix_col;
    logic [ROW_W-1:0]      pix_row;
    logic                  accept;
    logic                  stray;
    logic                  last_pix;
    logic                  win_ok;
    logic [DATA_WIDTH-1:0] line1_q;
    logic [DATA_WIDTH-1:0] line2_q;
    logic [DATA_WIDTH-1:0] new_top;
    logic [DATA_WIDTH-1:0] new_mid;
    logic [DATA_WIDTH-1:0] win [TAP_COUNT];

    // A sof pixel always starts a frame at (0,0), even when it cuts one short.
    assign accept   = valid_in && (sof_in || state == ST_ACTIVE);
    assign pix_col  = sof_in ? '0 : col;
    assign pix_row  = sof_in ? '0 : row;
    assign last_pix = (pix_col == COL_LAST) && (pix_row == ROW_LAST);
    assign stray    = valid_in && ((sof_in && state == ST_ACTIVE) ||
                                   (!sof_in && state == ST_DONE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (accept) begin
            state_next = last_pix ? ST_DONE : ST_ACTIVE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (pix_col == COL_LAST) begin
                col <= '0;
                row <= (pix_row == ROW_LAST) ? '0 : pix_row + ROW_W'(1);
            end else begin
                col <= pix_col + COL_W'(1);
                row <= pix_row;
            end
        end
    end

    // line1 holds the previous line; line2 receives what line1 is evicting.
    line_ram #(
        .DEPTH (IMG_WIDTH),
        .WIDTH (DATA_WIDTH)
    ) u_line1 (
        .clk   (clk),
        .we    (accept),
        .addr  (pix_col),
        .wdata (data_in),
        .rdata (line1_q)
    );

    line_ram #(
        .DEPTH (IMG_WIDTH),
        .WIDTH (DATA_WIDTH)
    ) u_line2 (
        .clk   (clk),
        .we    (accept),
        .addr  (pix_col),
        .wdata (line1_q),
        .rdata (line2_q)
    );

`ifdef BLUR_WINDOW_EDGE_FILL_EN
    assign new_top = (pix_row < ROW_W'(2)) ? '0 : line2_q;
    assign new_mid = (pix_row == '0) ? '0 : line1_q;
    assign win_ok  = 1'b1;
`else
    assign new_top = line2_q;
    assign new_mid = line1_q;
    assign win_ok  = (pix_row >= ROW_W'(2)) && (pix_col >= COL_W'(2));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < TAP_COUNT; k++) begin
                win[k] <= '0;
            end
        end else if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win[tap_index(r, 0)] <= win[tap_index(r, 1)];
                win[tap_index(r, 1)] <= win[tap_index(r, 2)];
            end
            win[tap_index(0, 2)] <= new_top;
            win[tap_index(1, 2)] <= new_mid;
            win[tap_index(2, 2)] <= data_in;
`ifdef BLUR_WINDOW_EDGE_FILL_EN
            // Columns left of the frame edge read as zero at the start of each line.
            if (pix_col == '0) begin
                for (int r = 0; r < 3; r++) begin
                    win[tap_index(r, 0)] <= '0;
                    win[tap_index(r, 1)] <= '0;
                end
            end
`endif
        end
    end

    for (genvar k = 0; k < TAP_COUNT; k++) begin : g_pack
        assign win_out[k*DATA_WIDTH +: DATA_WIDTH] = win[k];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_valid     <= 1'b0;
            eol_out       <= 1'b0;
            eof_out       <= 1'b0;
            freq_flag_out <= FREQ_1X1;
            frame_err     <= 1'b0;
        end else begin
            win_valid <= accept && win_ok;
            eol_out   <= accept && win_ok && (pix_col == COL_LAST);
            eof_out   <= accept && win_ok && last_pix;
            if (accept && sof_in) begin
                freq_flag_out <= freq_flag_in;
            end
            frame_err <= frame_err | stray;
        end
    end

endmodule

// File: tb/tb_blur_window_gen.sv
// Self-checking bench for blur_window_gen on a 10x10 image against a frame-array
// model; honours BLUR_WINDOW_EDGE_FILL_EN when defined.
module tb_blur_window_gen;
    import blur_pkg::*;

    localparam int DW = 12;
    localparam int W  = 10;
    localparam int H  = 10;
`ifdef BLUR_WINDOW_EDGE_FILL_EN
    localparam int EXP_PULSES = 100;
`else
    localparam int EXP_PULSES = 64;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic            valid_in;
    logic            sof_in;
    logic [DW-1:0]   data_in;
    logic [2:0]      freq_flag_in;
    logic [9*DW-1:0] win_out;
    logic            win_valid;
    logic [2:0]      freq_flag_out;
    logic            eol_out;
    logic            eof_out;
    logic            frame_err;

    blur_window_gen #(
        .DATA_WIDTH (DW),
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .valid_in      (valid_in),
        .sof_in        (sof_in),
        .data_in       (data_in),
        .freq_flag_in  (freq_flag_in),
        .win_out       (win_out),
        .win_valid     (win_valid),
        .freq_flag_out (freq_flag_out),
        .eol_out       (eol_out),
        .eof_out       (eof_out),
        .frame_err     (frame_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the pixels of the current frame stored by position.
    int              img [H][W];
    bit              m_in_frame;
    bit              m_done;
    int              m_row;
    int              m_col;
    logic            m_err;
    logic [2:0]      m_freq;
    int              acc_row;
    int              acc_col;
    logic [9*DW-1:0] exp_win;
    logic            exp_valid;
    logic            exp_eol;
    logic            exp_eof;

    int              pulses;
    bit              first_seen;
    bit              eof_seen;
    logic [9*DW-1:0] first_win;
    logic [DW-1:0]   last_tap8;
    logic [9*DW-1:0] pix11_win;
    int              rec_mode;
    logic [9*DW-1:0] seq_q [$];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9*DW-1:0] pack9(input int t [9]);
        logic [9*DW-1:0] v;
        v = '0;
        for (int k = 0; k < 9; k++) begin
            v[k*DW +: DW] = DW'(t[k]);
        end
        return v;
    endfunction

    task automatic model_reset();
        m_in_frame = 1'b0;
        m_done     = 1'b0;
        m_row      = 0;
        m_col      = 0;
        m_err      = 1'b0;
        m_freq     = 3'b000;
        exp_valid  = 1'b0;
        exp_eol    = 1'b0;
        exp_eof    = 1'b0;
        exp_win    = '0;
    endtask

    task automatic checkOutput();
        check("win_valid", {127'd0, win_valid}, {127'd0, exp_valid});
        check("eol_out", {127'd0, eol_out}, {127'd0, exp_eol});
        check("eof_out", {127'd0, eof_out}, {127'd0, exp_eof});
        check("freq_flag_out", {125'd0, freq_flag_out}, {125'd0, m_freq});
        check("frame_err", {127'd0, frame_err}, {127'd0, m_err});
        if (exp_valid) begin
            check("win_out", {20'd0, win_out}, {20'd0, exp_win});
            if (acc_row == 1 && acc_col == 1) pix11_win = win_out;
        end
        if (win_valid === 1'b1) begin
            pulses++;
            if (!first_seen) begin
                first_win  = win_out;
                first_seen = 1'b1;
            end
            if (eof_out === 1'b1) begin
                eof_seen  = 1'b1;
                last_tap8 = win_out[8*DW +: DW];
            end
            if (rec_mode == 1) begin
                seq_q.push_back(win_out);
            end else if (rec_mode == 2) begin
                check("seq_available", {127'd0, seq_q.size() > 0}, 128'd1);
                if (seq_q.size() > 0) check("seq_win", {20'd0, win_out}, {20'd0, seq_q.pop_front()});
            end
        end
    endtask

    task automatic applyStimulus(input logic v, input logic s, input logic [DW-1:0] d,
                                 input logic [2:0] f);
        bit acc;
        valid_in     = v;
        sof_in       = s;
        data_in      = d;
        freq_flag_in = f;
        acc = v && (s || m_in_frame);
        if (v && s && m_in_frame) m_err = 1'b1;
        if (v && !s && m_done) m_err = 1'b1;
        exp_valid = 1'b0;
        exp_eol   = 1'b0;
        exp_eof   = 1'b0;
        if (acc) begin
            if (s) begin
                m_row  = 0;
                m_col  = 0;
                m_freq = f;
            end
            acc_row = m_row;
            acc_col = m_col;
            img[m_row][m_col] = int'(d);
            for (int rr = 0; rr < 3; rr++) begin
                for (int cc = 0; cc < 3; cc++) begin
                    int pr, pc;
                    pr = m_row - 2 + rr;
                    pc = m_col - 2 + cc;
                    exp_win[(3*rr+cc)*DW +: DW] = (pr < 0 || pc < 0) ? '0 : DW'(img[pr][pc]);
                end
            end
`ifdef BLUR_WINDOW_EDGE_FILL_EN
            exp_valid = 1'b1;
`else
            exp_valid = (m_row >= 2) && (m_col >= 2);
`endif
            exp_eol = exp_valid && (m_col == W - 1);
            exp_eof = exp_valid && (m_row == H - 1) && (m_col == W - 1);
            if (m_row == H - 1 && m_col == W - 1) begin
                m_in_frame = 1'b0;
                m_done     = 1'b1;
                m_row      = 0;
                m_col      = 0;
            end else begin
                m_in_frame = 1'b1;
                m_done     = 1'b0;
                m_col++;
                if (m_col == W) begin
                    m_col = 0;
                    m_row++;
                end
            end
        end
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    // gap_mode: 0 continuous, 1 one idle cycle after every pixel, 2 random idles.
    task automatic runFrame(input int n_pix, input int gap_mode, input logic [2:0] f_sof,
                            input logic [2:0] f_mid, input bit rnd);
        pulses     = 0;
        first_seen = 1'b0;
        eof_seen   = 1'b0;
        for (int p = 0; p < n_pix; p++) begin
            int gaps;
            logic [DW-1:0] d;
            gaps = (gap_mode == 1) ? 1 : ((gap_mode == 2) ? int'($urandom_range(0, 2)) : 0);
            d = rnd ? DW'($urandom_range(0, 4095)) : DW'((p / W) * 10 + (p % W));
            applyStimulus(1'b1, p == 0, d, (p < 50) ? f_sof : f_mid);
            for (int g = 0; g < gaps; g++) begin
                applyStimulus(1'b0, 1'($urandom_range(0, 1)), DW'($urandom), 3'($urandom));
            end
        end
    endtask

    initial begin
        int taps_first [9];
        int taps_11 [9];
`ifdef BLUR_WINDOW_EDGE_FILL_EN
        taps_first = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
`else
        taps_first = '{0, 1, 2, 10, 11, 12, 20, 21, 22};
`endif
        taps_11 = '{0, 0, 0, 0, 0, 1, 0, 10, 11};
        rec_mode     = 0;
        pix11_win    = '0;
        rst_n        = 1'b0;
        valid_in     = 1'b0;
        sof_in       = 1'b0;
        data_in      = '0;
        freq_flag_in = 3'b000;
        model_reset();
        #12;
        check("reset_win_out", {20'd0, win_out}, 128'd0);
        check("reset_win_valid", {127'd0, win_valid}, 128'd0);
        check("reset_flags", {123'd0, eol_out, eof_out, freq_flag_out}, 128'd0);
        check("reset_frame_err", {127'd0, frame_err}, 128'd0);
        rst_n = 1'b1;

        $display("[TB] continuous frame, kernel code changes mid-frame");
        rec_mode = 1;
        runFrame(W * H, 0, 3'b010, 3'b100, 1'b0);
        rec_mode = 0;
        check("frame_a_pulses", 128'(pulses), 128'(EXP_PULSES));
        check("frame_a_first_win", {20'd0, first_win}, {20'd0, pack9(taps_first)});
        check("frame_a_eof_seen", {127'd0, eof_seen}, 128'd1);
        check("frame_a_last_tap8", {116'd0, last_tap8}, 128'd99);
        check("frame_a_freq_hold", {125'd0, freq_flag_out}, {125'd0, 3'b010});
`ifdef BLUR_WINDOW_EDGE_FILL_EN
        check("frame_a_pix11_win", {20'd0, pix11_win}, {20'd0, pack9(taps_11)});
`endif

        $display("[TB] valid toggled every other cycle");
        rec_mode = 2;
        runFrame(W * H, 1, 3'b100, 3'b010, 1'b0);
        rec_mode = 0;
        check("frame_b_pulses", 128'(pulses), 128'(EXP_PULSES));
        check("frame_b_seq_drained", 128'(seq_q.size()), 128'd0);
        check("frame_b_freq", {125'd0, freq_flag_out}, {125'd0, 3'b100});
        check("frame_b_err_clear", {127'd0, frame_err}, 128'd0);

        $display("[TB] early sof at pixel 37");
        runFrame(37, 2, 3'b011, 3'b011, 1'b1);
        runFrame(W * H, 0, 3'b000, 3'b000, 1'b0);
        check("early_sof_err", {127'd0, frame_err}, 128'd1);
        check("early_sof_first_win", {20'd0, first_win}, {20'd0, pack9(taps_first)});
        check("early_sof_pulses", 128'(pulses), 128'(EXP_PULSES));

        $display("[TB] asynchronous reset at pixel 50");
        runFrame(50, 0, 3'b010, 3'b010, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_win_out", {20'd0, win_out}, 128'd0);
        check("async_rst_win_valid", {127'd0, win_valid}, 128'd0);
        check("async_rst_flags", {123'd0, eol_out, eof_out, freq_flag_out}, 128'd0);
        check("async_rst_frame_err", {127'd0, frame_err}, 128'd0);
        model_reset();
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, DW'($urandom), 3'b111);
        end
        runFrame(W * H, 2, 3'b011, 3'b001, 1'b1);
        check("post_rst_pulses", 128'(pulses), 128'(EXP_PULSES));
        check("post_rst_eof_seen", {127'd0, eof_seen}, 128'd1);

        $display("[TB] stray pixel after frame end");
        applyStimulus(1'b1, 1'b0, DW'($urandom), 3'b000);
        check("stray_err", {127'd0, frame_err}, 128'd1);
        applyStimulus(1'b0, 1'b0, '0, 3'b000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
